bcd_timer_n: RTL

BCD_TIMER_N -- requirements
Module: bcd_timer_n

---
 rtl/bcd_timer_n.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bcd_timer_n.sv
// BCD up/down stopwatch timer with a RUN/HOLD FSM, preset load and wrap/clamp.
// Optional lap capture is enabled by defining BCD_TIMER_N_LAP_EN.
module bcd_timer_n #(
  parameter int NUM_DIGITS = 4,
  parameter int SATURATE   = 0
) (
  input  logic                    clk1k,
  input  logic                    rst,
  input  logic                    tick_en,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    dir,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic [1:0]              state,
  output logic                    zero,
  output logic                    ovf,
  output logic [4*NUM_DIGITS-1:0] lap_bcd,
  output logic                    lap_valid
);

  localparam int W = 4*NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t         st_q;
  state_t         st_d;
  logic [W-1:0]   bcd_q;
  logic [W-1:0]   step_val;
  logic [W-1:0]   load_sat;
  logic           ovf_q;
  logic           cy;
  logic [3:0]     dg;
  logic           do_step;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (start) st_d = RUN;
      RUN:     if (stop) st_d = HOLD;
      HOLD:    if (start && !stop) st_d = RUN;
      default: st_d = IDLE;
    endcase
  end

  assign do_step = (st_q == RUN) && tick_en;

  // cy is the carry (up) or borrow (down) rippling through digits;
  // leaving the top digit set means the count wrapped.
  always_comb begin
    step_val = bcd_q;
    cy       = 1'b1;
    dg       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dg = bcd_q[4*i +: 4];
      if (cy) begin
        if (dir)
          step_val[4*i +: 4] = (dg == 4'd0) ? 4'd9 : dg - 4'd1;
        else
          step_val[4*i +: 4] = (dg == 4'd9) ? 4'd0 : dg + 4'd1;
      end
      cy = cy & (dir ? (dg == 4'd0) : (dg == 4'd9));
    end
    if ((SATURATE != 0) && cy)
      step_val = bcd_q;
  end

  always_comb begin
    load_sat = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9)
        load_sat[4*i +: 4] = 4'd9;
      else
        load_sat[4*i +: 4] = load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk1k) begin
    if (rst) begin
      st_q  <= IDLE;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (clear) begin
      st_q  <= IDLE;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      bcd_q <= load_sat;
    end else begin
      st_q <= st_d;
      if (do_step) begin
        bcd_q <= step_val;
        if (cy)
          ovf_q <= 1'b1;
      end
    end
  end

  assign bcd   = bcd_q;
  assign state = st_q;
  assign zero  = (bcd_q == '0);
  assign ovf   = ovf_q;

`ifdef BCD_TIMER_N_LAP_EN
  logic [W-1:0] lap_q;
  logic         lapv_q;

  always_ff @(posedge clk1k) begin
    if (rst || clear) begin
      lap_q  <= '0;
      lapv_q <= 1'b0;
    end else begin
      lapv_q <= lap && (st_q == RUN);
      if (lap && (st_q == RUN))
        lap_q <= bcd_q;
    end
  end

  assign lap_bcd   = lap_q;
  assign lap_valid = lapv_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_bcd    = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule
